// File: rtl/field_scanner_if.sv
// -----------------------------------------------------------------------------
// field_scanner_if
//   Groups the playfield/apple inputs and the LED dot-matrix drive signals of
//   field_scanner into one bundle.
//   Signal names keep the scanner's point of view (_i into it, _o out of it).
//   Modports:
//     master : game logic / environment side; drives the field, apple and
//              enable inputs and observes the display outputs.
//     slave  : field_scanner itself.
//   Signals:
//     field_i    occupancy bitmap, bit x*SIZE_Y+y = cell (x,y)
//     apple_x_i  apple column
//     apple_y_i  apple row
//     enable_i   1 = scan continuously, 0 = blank once the frame ends
//     sclk_o     serial clock to the column shift chain
//     sdata_o    serial column data
//     latch_o    shift chain storage strobe
//     row_o      one-hot row select
//     row_en_o   row driver enable
//     frame_o    1-cycle pulse after the last row of a frame
// -----------------------------------------------------------------------------
interface field_scanner_if #(
  parameter int SIZE_X = 16,
  parameter int SIZE_Y = 16
);
  logic [SIZE_X*SIZE_Y-1:0] field_i;
  logic [3:0]               apple_x_i;
  logic [3:0]               apple_y_i;
  logic                     enable_i;
  logic                     sclk_o;
  logic                     sdata_o;
  logic                     latch_o;
  logic [SIZE_Y-1:0]        row_o;
  logic                     row_en_o;
  logic                     frame_o;

  modport master (
    output field_i, apple_x_i, apple_y_i, enable_i,
    input  sclk_o, sdata_o, latch_o, row_o, row_en_o, frame_o
  );

  modport slave (
    input  field_i, apple_x_i, apple_y_i, enable_i,
    output sclk_o, sdata_o, latch_o, row_o, row_en_o, frame_o
  );
endinterface

// File: rtl/field_scanner.sv
// -----------------------------------------------------------------------------
// field_scanner
//   Drives a row-multiplexed LED dot matrix from the playfield bitmap.
//   For each row the column bits (x = SIZE_X-1 down to 0) are shifted out to an
//   external shift-register chain, latched, and the row is then lit for
//   ROW_HOLD cycles.
//   The bitmap and apple position are snapshotted once per frame, so a frame
//   never mixes old and new field contents.
//   The apple cell blinks with a period of 2*BLINK_FRAMES frames.
// Ports:
//   clk50m_i  system clock
//   rst_i     synchronous reset, active-high
//   scan      field_scanner_if.slave (field/apple/enable in, display drive out)
// All display outputs are registered and are derived from the next state, so
// they change exactly when the state does and carry no decode glitches.
// -----------------------------------------------------------------------------
module field_scanner #(
  parameter int SIZE_X       = 16,
  parameter int SIZE_Y       = 16,
  parameter int CLK_DIV      = 25,
  parameter int ROW_HOLD     = 50000,
  parameter int BLINK_FRAMES = 32
) (
  input  logic           clk50m_i,
  input  logic           rst_i,
  field_scanner_if.slave scan
);

  localparam int XW   = (SIZE_X > 1) ? $clog2(SIZE_X) : 1;
  localparam int YW   = (SIZE_Y > 1) ? $clog2(SIZE_Y) : 1;
  localparam int NB   = SIZE_X * SIZE_Y;
  localparam int IW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int TMAX = (2 * CLK_DIV > ROW_HOLD) ? 2 * CLK_DIV : ROW_HOLD;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int BW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [TW-1:0] T_HALF      = TW'(CLK_DIV);
  localparam logic [TW-1:0] T_BIT_LAST  = TW'(2 * CLK_DIV - 1);
  localparam logic [TW-1:0] T_LTCH_LAST = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] T_HOLD_LAST = TW'(ROW_HOLD - 1);
  localparam logic [XW-1:0] X_FIRST     = XW'(SIZE_X - 1);
  localparam logic [YW-1:0] Y_LAST      = YW'(SIZE_Y - 1);
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_LATCH,
    S_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;       // cycles spent in the current bit/latch/hold
  logic [XW-1:0]   x_q, x_d;           // column currently being shifted
  logic [YW-1:0]   y_q, y_d;           // row currently being scanned
  logic            blink_on_q, blink_on_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic [NB-1:0]   snap_q, snap_d;
  logic [3:0]      apple_x_q, apple_x_d;
  logic [3:0]      apple_y_q, apple_y_d;

  logic            sclk_q, sclk_d;
  logic            sdata_q, sdata_d;
  logic            latch_q, latch_d;
  logic [SIZE_Y-1:0] row_q, row_d;
  logic            row_en_q, row_en_d;
  logic            frame_q, frame_d;

  // Lit state of cell (x,y). Apple coordinates outside the field never match
  // because the comparison is done at full integer width.
  function automatic logic cell_bit(
    input logic [NB-1:0] f,
    input logic [XW-1:0] x,
    input logic [YW-1:0] y,
    input logic [3:0]    ax,
    input logic [3:0]    ay,
    input logic          blink
  );
    logic [IW-1:0] idx;
    idx      = IW'(int'(x) * SIZE_Y + int'(y));
    cell_bit = f[idx] | (blink && (int'(ax) == int'(x)) && (int'(ay) == int'(y)));
  endfunction

  // NOTE: every variable gets a default before the case statement, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q + 1'b1;
    x_d         = x_q;
    y_d         = y_q;
    blink_on_d  = blink_on_q;
    blink_cnt_d = blink_cnt_q;
    snap_d      = snap_q;
    apple_x_d   = apple_x_q;
    apple_y_d   = apple_y_q;
    frame_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        y_d   = '0;
        if (scan.enable_i) state_d = S_LOAD;
      end
      S_LOAD: begin
        snap_d    = scan.field_i;
        apple_x_d = scan.apple_x_i;
        apple_y_d = scan.apple_y_i;
        tmr_d     = '0;
        x_d       = X_FIRST;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        if (tmr_q == T_BIT_LAST) begin
          tmr_d = '0;
          if (x_q == '0) state_d = S_LATCH;
          else           x_d     = x_q - 1'b1;
        end
      end
      S_LATCH: begin
        if (tmr_q == T_LTCH_LAST) begin
          tmr_d   = '0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (tmr_q == T_HOLD_LAST) begin
          tmr_d = '0;
          if (y_q == Y_LAST) begin
            y_d     = '0;
            frame_d = 1'b1;
            if (blink_cnt_q == BLINK_LAST) begin
              blink_cnt_d = '0;
              blink_on_d  = ~blink_on_q;
            end else begin
              blink_cnt_d = blink_cnt_q + 1'b1;
            end
            // enable_i is only consulted here, so a row is never cut short.
            state_d = scan.enable_i ? S_LOAD : S_IDLE;
          end else begin
            y_d     = y_q + 1'b1;
            x_d     = X_FIRST;
            state_d = S_SHIFT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs follow the next state; the snapshot is taken from snap_d so the
    // first bit after LOAD already sees the freshly captured bitmap.
    sclk_d   = (state_d == S_SHIFT) && (tmr_d >= T_HALF);
    sdata_d  = (state_d == S_SHIFT) &&
               cell_bit(snap_d, x_d, y_d, apple_x_d, apple_y_d, blink_on_q);
    latch_d  = (state_d == S_LATCH);
    row_en_d = (state_d == S_HOLD);
    row_d    = row_en_d ? (SIZE_Y'(1) << y_d) : '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk50m_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      blink_on_q  <= 1'b1;
      blink_cnt_q <= '0;
      sclk_q      <= 1'b0;
      sdata_q     <= 1'b0;
      latch_q     <= 1'b0;
      row_q       <= '0;
      row_en_q    <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      x_q         <= x_d;
      y_q         <= y_d;
      blink_on_q  <= blink_on_d;
      blink_cnt_q <= blink_cnt_d;
      sclk_q      <= sclk_d;
      sdata_q     <= sdata_d;
      latch_q     <= latch_d;
      row_q       <= row_d;
      row_en_q    <= row_en_d;
      frame_q     <= frame_d;
    end
  end

  // NOTE: the snapshot storage is deliberately not reset; it is always written
  // in LOAD before SHIFT reads it, and leaving reset off keeps it plain storage.
  always_ff @(posedge clk50m_i) begin
    snap_q    <= snap_d;
    apple_x_q <= apple_x_d;
    apple_y_q <= apple_y_d;
  end

  assign scan.sclk_o   = sclk_q;
  assign scan.sdata_o  = sdata_q;
  assign scan.latch_o  = latch_q;
  assign scan.row_o    = row_q;
  assign scan.row_en_o = row_en_q;
  assign scan.frame_o  = frame_q;

endmodule
